// File: rtl/fc_layer_sequencer.sv
// Runs one fully connected layer by time-sharing a single external dot-product unit
// across all neurons, with a start/busy/done handshake and a per-neuron watchdog.
module fc_layer_sequencer #(
  parameter int VLEN    = 1,
  parameter int NEURONS = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [32*VLEN-1:0]            in_vec,
  input  logic [32*VLEN*NEURONS-1:0]    weights,
  output logic [32*VLEN-1:0]            dp_a,
  output logic [32*VLEN-1:0]            dp_b,
  input  logic [31:0]                   dp_result,
  input  logic                          dp_done,
  output logic [32*NEURONS-1:0]         results,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [$clog2(NEURONS):0]      err_idx
);

  localparam int VW = 32 * VLEN;
  localparam int NW = $clog2(NEURONS) + 1;
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_LOAD, S_ARM, S_WAIT, S_NEXT, S_FINISH
  } state_t;

  state_t          state_reg, state_next;
  logic [VW-1:0]   dp_a_reg, dp_b_reg, row_sel;
  logic [NW-1:0]   n_reg, err_idx_reg;
  logic [CW-1:0]   wait_cnt_reg, wait_inc;
  logic            busy_reg, done_reg, error_reg;
  logic            wait_hit, last_neuron;

  assign wait_inc    = wait_cnt_reg + 1'b1;
  assign wait_hit    = (wait_inc == CW'(TIMEOUT));
  assign last_neuron = (n_reg == NW'(NEURONS - 1));

  always_comb begin
    row_sel = '0;
    for (int i = 0; i < NEURONS; i++) begin
      if (n_reg == NW'(i)) row_sel = weights[VW*i +: VW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_FLUSH;
      S_FLUSH:  state_next = S_LOAD;
      S_LOAD:   state_next = S_ARM;
      S_ARM:    state_next = S_WAIT;
      S_WAIT:   if (dp_done || wait_hit) state_next = S_NEXT;
      S_NEXT:   state_next = last_neuron ? S_FINISH : S_FLUSH;
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Registers take the value belonging to the state being entered, so dp_b reads
  // zero throughout FLUSH and the weight row throughout LOAD/ARM/WAIT.
  // dp_a doubles as the latched copy of in_vec for the whole run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_a_reg     <= '0;
      dp_b_reg     <= '0;
      n_reg        <= '0;
      wait_cnt_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
      err_idx_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            dp_a_reg  <= in_vec;
            dp_b_reg  <= '0;
            n_reg     <= '0;
            error_reg <= 1'b0;
            busy_reg  <= 1'b1;
          end
        end
        S_FLUSH: begin
          dp_b_reg     <= row_sel;
          wait_cnt_reg <= '0;
        end
        S_WAIT: begin
          wait_cnt_reg <= wait_inc;
          if (!dp_done && wait_hit) begin
            error_reg   <= 1'b1;
            err_idx_reg <= n_reg;
          end
        end
        S_NEXT: begin
          if (last_neuron) begin
            done_reg <= 1'b1;
            busy_reg <= 1'b0;
          end else begin
            n_reg    <= n_reg + 1'b1;
            dp_b_reg <= '0;
          end
        end
        S_FINISH: done_reg <= 1'b0;
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < NEURONS; gi++) begin : g_result
    logic [31:0] res_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        res_reg <= '0;
      end else if (state_reg == S_WAIT && n_reg == NW'(gi)) begin
        if (dp_done)       res_reg <= dp_result;
        else if (wait_hit) res_reg <= QNAN;
      end
    end
    assign results[32*gi +: 32] = res_reg;
  end

  assign dp_a    = dp_a_reg;
  assign dp_b    = dp_b_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign error   = error_reg;
  assign err_idx = err_idx_reg;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Randomized bench: behavioural float dot-product unit plus a layer-level reference
// model that predicts results, error flags and run length from the layer rules.
module tb_fc_layer_sequencer;

  localparam int VLEN    = 4;
  localparam int NEURONS = 3;
  localparam int TIMEOUT = 16;
  localparam int VW      = 32 * VLEN;
  localparam int NW      = $clog2(NEURONS) + 1;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic [VW-1:0]           in_vec = '0;
  logic [VW*NEURONS-1:0]   weights = '0;
  logic [VW-1:0]           dp_a, dp_b;
  logic [31:0]             dp_result = '0;
  logic                    dp_done = 1'b0;
  logic [32*NEURONS-1:0]   results;
  logic                    busy, done, error;
  logic [NW-1:0]           err_idx;

  fc_layer_sequencer #(.VLEN(VLEN), .NEURONS(NEURONS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_vec(in_vec), .weights(weights),
    .dp_a(dp_a), .dp_b(dp_b), .dp_result(dp_result), .dp_done(dp_done),
    .results(results), .busy(busy), .done(done), .error(error), .err_idx(err_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic real dot(input logic [VW-1:0] a, input logic [VW-1:0] b);
    real acc = 0.0;
    for (int k = 0; k < VLEN; k++) acc += f2r(a[32*k +: 32]) * f2r(b[32*k +: 32]);
    return acc;
  endfunction

  function automatic logic [VW-1:0] mk4(input real a, input real b, input real c, input real d);
    return {r2f(d), r2f(c), r2f(b), r2f(a)};
  endfunction

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] v;
    for (int k = 0; k < VLEN; k++) v[32*k +: 32] = r2f(real'(int'($urandom_range(0, 12)) - 6) * 0.5);
    return v;
  endfunction

  // Behavioural unit: result appears unit_lat clocks after operands settle and
  // stays until they change; a stalled row never completes.
  int            unit_lat = 3;
  int            lat_cnt = 0;
  logic          stall_en = 1'b0;
  logic [VW-1:0] stall_row = '0;
  logic [VW-1:0] last_a = '0, last_b = '0;

  always @(posedge clk) begin
    if (dp_a !== last_a || dp_b !== last_b) begin
      last_a  <= dp_a;
      last_b  <= dp_b;
      dp_done <= 1'b0;
      lat_cnt <= unit_lat;
    end else if (lat_cnt > 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1 && !(stall_en && dp_b == stall_row)) begin
        dp_done   <= 1'b1;
        dp_result <= r2f(dot(dp_a, dp_b));
      end
    end
  end

  // Layer reference model
  logic [31:0]   exp_res [NEURONS] = '{default: 32'd0};
  logic          exp_err = 1'b0;
  logic [NW-1:0] exp_err_idx = '0;
  int            exp_cycles;

  function automatic logic [383:0] exp_vec();
    logic [383:0] v = '0;
    for (int i = 0; i < NEURONS; i++) v[32*i +: 32] = exp_res[i];
    return v;
  endfunction

  task automatic predict(input int lat, input logic stl, input logic [VW-1:0] srow);
    logic [VW-1:0] row;
    unit_lat = lat; stall_en = stl; stall_row = srow;
    exp_err = 1'b0; exp_cycles = 0;
    for (int i = 0; i < NEURONS; i++) begin
      row = weights[VW*i +: VW];
      if (stl && row == srow) begin
        exp_res[i] = QNAN; exp_err = 1'b1; exp_err_idx = NW'(i);
        exp_cycles += TIMEOUT + 4;
      end else begin
        exp_res[i] = r2f(dot(in_vec, row));
        exp_cycles += lat + 4;
      end
    end
  endtask

  task automatic wait_done(input int poke_at, output int cycles, output int busy_drops);
    logic seen = 1'b0;
    cycles = 0; busy_drops = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      start = (cycles == poke_at);
      @(posedge clk); #1;
      cycles++;
      if (done) seen = 1'b1;
      else if (!busy) busy_drops++;
    end
    start = 1'b0;
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic end_checks(input string tag, input int cycles, input int busy_drops);
    check({tag, "_cycles"}, cycles, exp_cycles);
    check({tag, "_busy_hold"}, busy_drops, 0);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_results"}, results, exp_vec());
    check({tag, "_error"}, error, exp_err);
    if (exp_err) check({tag, "_err_idx"}, err_idx, exp_err_idx);
    @(posedge clk); #1;
    check({tag, "_done_single"}, done, 0);
  endtask

  task automatic run(input string tag, input int lat, input logic stl, input logic [VW-1:0] srow,
                     input int poke_at);
    int cyc, drops;
    logic [VW-1:0] vin;
    predict(lat, stl, srow);
    vin = in_vec;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_vec = rnd_vec();
    check({tag, "_busy_start"}, busy, 1);
    check({tag, "_flush_a"}, dp_a, vin);
    check({tag, "_flush_b"}, dp_b, 0);
    wait_done(poke_at, cyc, drops);
    $display("run %s lat=%0d stall=%0d cycles=%0d results=%h err=%0d", tag, lat, stl, cyc, results, error);
    end_checks(tag, cyc, drops);
  endtask

  initial begin
    int cyc, drops;
    repeat (2) @(posedge clk);
    #1;
    check("rst_results", results, 0);
    check("rst_flags", {busy, done, error}, 0);
    check("rst_err_idx", err_idx, 0);
    check("rst_dp", {dp_a, dp_b}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    in_vec  = mk4(1, 2, 3, 4);
    weights = {mk4(-1, 0, 0, 1), mk4(0.5, 0.5, 0.5, 0.5), mk4(1, 1, 1, 1)};
    run("basic", 3, 1'b0, '0, -1);
    check("basic_const", results, {32'h4040_0000, 32'h40A0_0000, 32'h4120_0000});

    in_vec  = mk4(1, 1, 1, 1);
    weights = {3{mk4(2, 2, 2, 2)}};
    run("same_rows", 2, 1'b0, '0, -1);
    check("same_const", results, {3{32'h4100_0000}});

    in_vec  = mk4(1, 2, 3, 4);
    weights = {mk4(1, 0, 0, 0), mk4(3, 3, 1, 1), mk4(1, 1, 1, 1)};
    run("stall", 2, 1'b1, mk4(3, 3, 1, 1), -1);
    check("stall_nan", results[63:32], QNAN);
    run("clear_err", 2, 1'b0, '0, -1);

    run("mid_start", 3, 1'b0, '0, 3 + 6);

    in_vec = rnd_vec();
    for (int i = 0; i < NEURONS; i++) weights[VW*i +: VW] = rnd_vec();
    predict(3, 1'b0, '0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2 * (3 + 4) + 4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_results", results, 0);
    check("arst_flags", {busy, done, error}, 0);
    check("arst_dp", {dp_a, dp_b}, 0);
    for (int i = 0; i < NEURONS; i++) exp_res[i] = 32'd0;
    exp_err_idx = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run("after_rst", 3, 1'b0, '0, -1);

    // start held high: back-to-back runs with one IDLE cycle between
    predict(2, 1'b0, '0);
    start = 1'b1;
    @(posedge clk); #1;
    for (int r = 0; r < 2; r++) begin
      cyc = 0;
      while (!done && cyc < 3000) begin
        @(posedge clk); #1;
        cyc++;
      end
      $display("run held%0d cycles=%0d results=%h", r, cyc, results);
      check("held_cycles", cyc, exp_cycles);
      check("held_results", results, exp_vec());
      @(posedge clk); #1;
      check("held_idle", {busy, done}, 2'b00);
      if (r == 1) start = 1'b0;
      @(posedge clk); #1;
      check("held_restart", busy, r == 0);
    end

    for (int t = 0; t < 8; t++) begin
      int sidx;
      logic stl;
      in_vec = rnd_vec();
      for (int i = 0; i < NEURONS; i++) weights[VW*i +: VW] = rnd_vec();
      stl  = ($urandom_range(0, 3) == 0);
      sidx = $urandom_range(0, NEURONS - 1);
      run($sformatf("rand%0d", t), $urandom_range(1, 6), stl, weights[VW*sidx +: VW], -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
